// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: frame-walker state encodings, parity sense
// constants and the parity-check helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // High when the received parity bit disagrees with the one implied by the data.
  function automatic logic par_bad(input logic rx_bit, input logic run_par, input logic typ);
    logic exp_bit;
    exp_bit = (typ == PAR_ODD) ? ~run_par : run_par;
    return rx_bit ^ exp_bit;
  endfunction

endpackage

// File: rtl/uart_frame_check_if.sv
// Bit-decision and frame-status bundle between the RX sampler, the frame
// checker (slave) and the RX control FSM.
interface uart_frame_check_if;
  logic frame_start;
  logic bit_valid;
  logic sampled_bit;
  logic par_en;
  logic par_typ;
  logic strt_glitch;
  logic par_err;
  logic stp_err;
  logic frame_done;
  logic frame_abort;
  logic busy;

  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_typ,
    input  strt_glitch, par_err, stp_err, frame_done, frame_abort, busy
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_typ,
    output strt_glitch, par_err, stp_err, frame_done, frame_abort, busy
  );
endinterface

// File: rtl/uart_err_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module uart_err_sat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count events, holding at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/uart_frame_check.sv
// UART RX frame checker: walks start/data/parity/stop bits and flags errors.
// Optional saturating error counters under UART_FRAME_CHK_ERR_CNT_EN.
module uart_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  uart_frame_check_if.slave  bus
`ifdef UART_FRAME_CHK_ERR_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [ERR_CNT_W-1:0] glitch_cnt,
  output logic [ERR_CNT_W-1:0] par_cnt,
  output logic [ERR_CNT_W-1:0] stp_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9)) begin : g_bad_data_width
    $error("uart_frame_check: DATA_WIDTH must be 5..9");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_frame_check: STOP_BITS must be 1..2");
  end
  if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    $error("uart_frame_check: ERR_CNT_W must be >= 1");
  end

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt;
  logic             r_run_par;
  logic             w_run_par;
  logic             r_par_en;
  logic             w_par_en;
  logic             r_par_typ;
  logic             w_par_typ;
  logic             r_strt_glitch;
  logic             w_strt_glitch;
  logic             r_par_err;
  logic             w_par_err;
  logic             r_stp_err;
  logic             w_stp_err;
  logic             r_frame_done;
  logic             w_frame_done;
  logic             r_frame_abort;
  logic             w_frame_abort;
  logic             r_busy;
  logic             w_busy;
  logic             w_data_last;
  logic             w_stop_last;

  assign w_data_last = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_stop_last = (r_bit_cnt == CNT_W'(STOP_BITS - 1));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; frame_start overrides any bit on the same edge.
  always_comb begin
    w_next_state = r_state;
    if (bus.frame_start) begin
      w_next_state = ST_START;
    end else if (bus.bit_valid) begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_IDLE;
        ST_START: w_next_state = bus.sampled_bit ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (w_data_last) begin
            w_next_state = r_par_en ? ST_PAR : ST_STOP;
          end else begin
            w_next_state = ST_DATA;
          end
        end
        ST_PAR:   w_next_state = ST_STOP;
        ST_STOP: begin
          if (w_stop_last) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_STOP;
          end
        end
        default:  w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = (r_state > ST_STOP) ? ST_IDLE : r_state;
    end
  end

  // Bit counter, running parity and per-frame parity configuration.
  always_comb begin
    w_bit_cnt = r_bit_cnt;
    w_run_par = r_run_par;
    w_par_en  = r_par_en;
    w_par_typ = r_par_typ;
    if (bus.frame_start) begin
      w_bit_cnt = '0;
      w_run_par = 1'b0;
      w_par_en  = bus.par_en;
      w_par_typ = bus.par_typ;
    end else if (bus.bit_valid) begin
      case (r_state)
        ST_DATA: begin
          w_run_par = r_run_par ^ bus.sampled_bit;
          w_bit_cnt = w_data_last ? '0 : (r_bit_cnt + CNT_W'(1));
        end
        ST_STOP: w_bit_cnt = w_stop_last ? '0 : (r_bit_cnt + CNT_W'(1));
        default: w_bit_cnt = r_bit_cnt;
      endcase
    end else begin
      w_bit_cnt = r_bit_cnt;
    end
  end

  // Output decode: flags stay sticky until a new frame is accepted.
  always_comb begin
    w_strt_glitch = r_strt_glitch;
    w_par_err     = r_par_err;
    w_stp_err     = r_stp_err;
    w_frame_done  = 1'b0;
    w_frame_abort = 1'b0;
    if (bus.frame_start) begin
      w_strt_glitch = 1'b0;
      w_par_err     = 1'b0;
      w_stp_err     = 1'b0;
    end else if (bus.bit_valid) begin
      case (r_state)
        ST_START: begin
          if (bus.sampled_bit) begin
            w_strt_glitch = 1'b1;
            w_frame_abort = 1'b1;
          end else begin
            w_strt_glitch = 1'b0;
          end
        end
        ST_PAR:  w_par_err = par_bad(bus.sampled_bit, r_run_par, r_par_typ);
        ST_STOP: begin
          if (!bus.sampled_bit) begin
            w_stp_err = 1'b1;
          end else begin
            w_stp_err = r_stp_err;
          end
          w_frame_done = w_stop_last;
        end
        default: w_frame_done = 1'b0;
      endcase
    end else begin
      w_frame_done = 1'b0;
    end
    w_busy = (w_next_state != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt     <= '0;
      r_run_par     <= 1'b0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_bit_cnt     <= w_bit_cnt;
      r_run_par     <= w_run_par;
      r_par_en      <= w_par_en;
      r_par_typ     <= w_par_typ;
      r_strt_glitch <= w_strt_glitch;
      r_par_err     <= w_par_err;
      r_stp_err     <= w_stp_err;
      r_frame_done  <= w_frame_done;
      r_frame_abort <= w_frame_abort;
      r_busy        <= w_busy;
    end
  end

  assign bus.strt_glitch = r_strt_glitch;
  assign bus.par_err     = r_par_err;
  assign bus.stp_err     = r_stp_err;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_abort = r_frame_abort;
  assign bus.busy        = r_busy;

`ifdef UART_FRAME_CHK_ERR_CNT_EN
  // Counters step on the same edge that raises the corresponding pulse.
  uart_err_sat_cnt #(.W(ERR_CNT_W)) u_glitch_cnt (
    .CLK(CLK), .RST(RST), .clr(cnt_clr), .inc(w_frame_abort), .cnt(glitch_cnt)
  );
  uart_err_sat_cnt #(.W(ERR_CNT_W)) u_par_cnt (
    .CLK(CLK), .RST(RST), .clr(cnt_clr), .inc(w_frame_done & w_par_err), .cnt(par_cnt)
  );
  uart_err_sat_cnt #(.W(ERR_CNT_W)) u_stp_cnt (
    .CLK(CLK), .RST(RST), .clr(cnt_clr), .inc(w_frame_done & w_stp_err), .cnt(stp_cnt)
  );
`endif

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: dut1 is 8N1-style (1 stop), dut2 has 2 stop bits
// and 2-bit error counters. Frame results are scoreboarded per DUT.
module tb_uart_frame_check;
  import uart_rx_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_frame_check_if if1 ();
  uart_frame_check_if if2 ();

`ifdef UART_FRAME_CHK_ERR_CNT_EN
  logic       clr1, clr2;
  logic [7:0] g1, p1, s1;
  logic [1:0] g2, p2, s2;
`endif

  uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(8)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1.slave)
`ifdef UART_FRAME_CHK_ERR_CNT_EN
    , .cnt_clr(clr1), .glitch_cnt(g1), .par_cnt(p1), .stp_cnt(s1)
`endif
  );

  uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .bus(if2.slave)
`ifdef UART_FRAME_CHK_ERR_CNT_EN
    , .cnt_clr(clr2), .glitch_cnt(g2), .par_cnt(p2), .stp_cnt(s2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  // {strt_glitch, par_err, stp_err, frame_abort} expected at each done/abort pulse
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  typedef struct {
    int         d;
    logic       sb;
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pb;
    logic       s0;
    logic       s1;
    logic [3:0] exp;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic [3:0] act, input logic both);
    logic [3:0] e;
    check("done_abort_exclusive", {31'd0, both}, 32'd0);
    if ((d == 0 && q1.size() == 0) || (d == 1 && q2.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse dut%0d: got flags %b expected no pulse", d + 1, act);
    end else begin
      e = (d == 0) ? q1.pop_front() : q2.pop_front();
      check($sformatf("frame_result_dut%0d", d + 1), {28'd0, act}, {28'd0, e});
    end
  endtask

  // Scoreboard side: compare every completion/abort pulse against the queue.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (if1.frame_done || if1.frame_abort)
        mon(0, {if1.strt_glitch, if1.par_err, if1.stp_err, if1.frame_abort},
            if1.frame_done & if1.frame_abort);
      if (if2.frame_done || if2.frame_abort)
        mon(1, {if2.strt_glitch, if2.par_err, if2.stp_err, if2.frame_abort},
            if2.frame_done & if2.frame_abort);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input int d, input logic fs, input logic bv, input logic sb);
    if (d == 0) begin
      if1.frame_start = fs; if1.bit_valid = bv; if1.sampled_bit = sb;
    end else begin
      if2.frame_start = fs; if2.bit_valid = bv; if2.sampled_bit = sb;
    end
  endtask

  task automatic set_clr(input int d, input logic c);
`ifdef UART_FRAME_CHK_ERR_CNT_EN
    if (d == 0) clr1 = c;
    else        clr2 = c;
`endif
  endtask

  task automatic send_bit(input int d, input logic b, input logic clr);
    set_in(d, 1'b0, 1'b1, b);
    set_clr(d, clr);
    tick();
    set_in(d, 1'b0, 1'b0, 1'b0);
    tick();
    set_clr(d, 1'b0);
    tick();
  endtask

  task automatic start_frame(input int d, input logic pe, input logic pt);
    if (d == 0) begin if1.par_en = pe; if1.par_typ = pt; end
    else        begin if2.par_en = pe; if2.par_typ = pt; end
    set_in(d, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(d, 1'b0, 1'b0, 1'b0);
    if (d == 0) begin if1.par_en = 1'b0; if1.par_typ = 1'b0; end
    else        begin if2.par_en = 1'b0; if2.par_typ = 1'b0; end
    tick();
  endtask

  task automatic send_frame(input int d, input logic sb, input logic [7:0] data,
                            input logic pe, input logic pt, input logic pb,
                            input logic s0, input logic s1, input logic clr_last);
    start_frame(d, pe, pt);
    send_bit(d, sb, 1'b0);
    if (!sb) begin
      for (int i = 0; i < 8; i++) send_bit(d, data[i], 1'b0);
      if (pe) send_bit(d, pb, 1'b0);
      if (d == 0) begin
        send_bit(d, s0, clr_last);
      end else begin
        send_bit(d, s0, 1'b0);
        send_bit(d, s1, clr_last);
      end
    end
  endtask

  task automatic push_exp(input int d, input logic [3:0] e);
    if (d == 0) q1.push_back(e);
    else        q2.push_back(e);
  endtask

  initial begin
    RST = 1'b0;
    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    if1.par_en = 1'b0; if1.par_typ = 1'b0;
    if2.par_en = 1'b0; if2.par_typ = 1'b0;
    set_clr(0, 1'b0);
    set_clr(1, 1'b0);

    vt[0]  = '{0, 1'b0, 8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 4'b0000};
    vt[1]  = '{0, 1'b0, 8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 4'b0100};
    vt[2]  = '{0, 1'b0, 8'h07, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 4'b0000};
    vt[3]  = '{0, 1'b1, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 4'b1001};
    vt[4]  = '{0, 1'b0, 8'h3C, 1'b1, PAR_ODD,  1'b0, 1'b1, 1'b1, 4'b0100};
    vt[5]  = '{0, 1'b0, 8'hFF, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b1, 4'b0010};
    vt[6]  = '{1, 1'b0, 8'h55, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, 4'b0010};
    vt[7]  = '{1, 1'b0, 8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b1, 4'b0010};
    vt[8]  = '{1, 1'b0, 8'h12, 1'b1, PAR_ODD,  1'b1, 1'b1, 1'b1, 4'b0000};
    vt[9]  = '{0, 1'b0, 8'h00, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 4'b0000};
    vt[10] = '{1, 1'b1, 8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1, 4'b1001};
    vt[11] = '{1, 1'b0, 8'hF0, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b0, 4'b0110};

    // Reset state
    tick(); tick();
    check("reset_outputs_dut1", {26'd0, if1.strt_glitch, if1.par_err, if1.stp_err,
          if1.frame_done, if1.frame_abort, if1.busy}, 32'd0);
    check("reset_outputs_dut2", {26'd0, if2.strt_glitch, if2.par_err, if2.stp_err,
          if2.frame_done, if2.frame_abort, if2.busy}, 32'd0);
`ifdef UART_FRAME_CHK_ERR_CNT_EN
    check("reset_counters", {14'd0, g1, p1, s2}, 32'd0);
`endif
    RST = 1'b1;
    tick();

    // Table-driven frames
    for (int k = 0; k < 12; k++) begin
      push_exp(vt[k].d, vt[k].exp);
      send_frame(vt[k].d, vt[k].sb, vt[k].data, vt[k].pe, vt[k].pt, vt[k].pb,
                 vt[k].s0, vt[k].s1, 1'b0);
      tick();
      if (vt[k].d == 0)
        check($sformatf("sticky_flags_vec%0d", k),
              {28'd0, if1.strt_glitch, if1.par_err, if1.stp_err, if1.busy},
              {28'd0, vt[k].exp[3:1], 1'b0});
      else
        check($sformatf("sticky_flags_vec%0d", k),
              {28'd0, if2.strt_glitch, if2.par_err, if2.stp_err, if2.busy},
              {28'd0, vt[k].exp[3:1], 1'b0});
    end

    // Start glitch: abort pulse, then busy low
    start_frame(0, 1'b0, 1'b0);
    check("busy_in_start", {31'd0, if1.busy}, 32'd1);
    push_exp(0, 4'b1001);
    set_in(0, 1'b0, 1'b1, 1'b1);
    tick();
    check("abort_pulse", {30'd0, if1.frame_abort, if1.frame_done}, 32'd2);
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();
    check("busy_after_abort", {31'd0, if1.busy}, 32'd0);

    // Restart mid-frame: stp_err cleared, dropped frame gives no pulse
    push_exp(0, 4'b0010);
    send_frame(0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stp_err_sticky", {31'd0, if1.stp_err}, 32'd1);
    set_in(0, 1'b1, 1'b0, 1'b0);
    tick();
    check("flags_clear_on_start", {29'd0, if1.stp_err, if1.busy, if1.strt_glitch}, 32'd2);
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
    push_exp(0, 4'b0000);
    send_frame(0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // frame_start with a same-edge bit: that bit must not be taken as the start bit
    set_in(0, 1'b1, 1'b1, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b0, 1'b0);
    tick();
    check("start_wins_over_bit", {30'd0, if1.busy, if1.strt_glitch}, 32'd2);
    push_exp(0, 4'b0000);
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(0, i[0], 1'b0);
    send_bit(0, 1'b1, 1'b0);

    // Two stop bits, second one bad
    start_frame(1, 1'b0, 1'b0);
    send_bit(1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1, 1'b0, 1'b0);
    send_bit(1, 1'b1, 1'b0);
    check("busy_between_stops", {30'd0, if2.busy, if2.stp_err}, 32'd2);
    push_exp(1, 4'b0010);
    send_bit(1, 1'b0, 1'b0);
    check("stp_err_second_stop", {30'd0, if2.stp_err, if2.busy}, 32'd2);
    start_frame(1, 1'b0, 1'b0);
    check("stp_err_cleared", {31'd0, if2.stp_err}, 32'd0);
    push_exp(1, 4'b1001);
    send_bit(1, 1'b1, 1'b0);

    // Reset mid-frame
    start_frame(0, 1'b0, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    check("busy_before_reset", {31'd0, if1.busy}, 32'd1);
    RST = 1'b0;
    #2;
    check("reset_midframe", {26'd0, if1.strt_glitch, if1.par_err, if1.stp_err,
          if1.frame_done, if1.frame_abort, if1.busy}, 32'd0);
    tick();
    RST = 1'b1;
    send_bit(0, 1'b1, 1'b0);
    check("idle_after_reset", {31'd0, if1.busy}, 32'd0);

`ifdef UART_FRAME_CHK_ERR_CNT_EN
    // Counter saturation and clear priority (dut2, 2-bit counters)
    set_clr(1, 1'b1);
    tick();
    set_clr(1, 1'b0);
    check("cnt_cleared", {26'd0, g2, p2, s2}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      push_exp(1, 4'b0100);
      send_frame(1, 1'b0, 8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    check("par_cnt_saturated", {30'd0, p2}, 32'd3);
    check("other_cnts_idle", {28'd0, g2, s2}, 32'd0);
    push_exp(1, 4'b0100);
    send_frame(1, 1'b0, 8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_beats_inc", {30'd0, p2}, 32'd0);
`endif

    tick(); tick();
    check("queue1_drained", q1.size(), 32'd0);
    check("queue2_drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
